// File: rtl/systolic_ctrl.sv
// Matmul sequencer for the systolic array: config, weight load/burst/switch/settle,
// skewed activation streaming and result counting. Perf counters under SYSTOLIC_CTRL_PERF_EN.
module systolic_skew_lane #(
  parameter int DLY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_i,
  input  logic       s_i,
  output logic [7:0] d_o,
  output logic       s_o
);
  logic [DLY:0][8:0] pipe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else begin
      pipe_q[0] <= {s_i, d_i};
      for (int k = 1; k <= DLY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign {s_o, d_o} = pipe_q[DLY];
endmodule

module systolic_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [15:0]          cmd_cols,
  input  logic [15:0]          cmd_rows,
  input  logic                 cmd_load_w,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [8*WIDTH-1:0]   w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [8*WIDTH-1:0]   a_data,
  output logic [8*WIDTH-1:0]   sys_data_out,
  output logic [WIDTH-1:0]     sys_start_out,
  output logic [8*WIDTH-1:0]   sys_weight_out,
  output logic [WIDTH-1:0]     sys_accept_w_out,
  output logic                 sys_switch_out,
  output logic [15:0]          col_size_out,
  output logic                 col_size_valid_out,
  input  logic [WIDTH-1:0]     sys_valid_in,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stall
);
  localparam int          IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [15:0] W16 = 16'(WIDTH);

  typedef enum logic [3:0] {IDLE, CFG, LOAD_W, BURST, SWITCH, SETTLE, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [15:0] cnt_q, cnt_d, acnt_q, acnt_d, rcnt_q, rcnt_d;
  logic [15:0] cols_q, cols_d, rows_q, rows_d;
  logic        ldw_q, ldw_d, errf_q, errf_d;
  logic [WIDTH-1:0][8*WIDTH-1:0] wbuf_q;

  logic                 cmd_ready_q, w_ready_q, a_ready_q, switch_q, csv_q, done_q, err_q;
  logic [15:0]          col_size_q;
  logic [8*WIDTH-1:0]   weight_q, inj_d_q;
  logic [WIDTH-1:0]     accept_q, inj_s_q, colmask_q, colmask_d;
  logic [8*WIDTH-1:0]   wrow, wrow_m, adat_m;

  logic acc, bad, w_hs, a_hs, last_vld;
  logic [IW-1:0] lidx, bidx, widx;

  assign acc      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign bad      = (cmd_cols == 16'd0) || (cmd_cols > W16);
  assign w_hs     = w_valid && w_ready_q;
  assign a_hs     = a_valid && a_ready_q;
  assign lidx     = IW'(cols_q - 16'd1);
  assign last_vld = sys_valid_in[lidx];
  assign widx     = IW'(cnt_q);
  assign bidx     = IW'(cnt_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    rcnt_d  = rcnt_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    ldw_d   = ldw_q;
    errf_d  = errf_q;
    // results arriving during STREAM count too; extras past rows are dropped
    if ((state_q == STREAM || state_q == DRAIN) && last_vld && rcnt_q < rows_q)
      rcnt_d = rcnt_q + 16'd1;
    case (state_q)
      IDLE: if (acc) begin
        cols_d  = cmd_cols;
        rows_d  = cmd_rows;
        ldw_d   = cmd_load_w;
        errf_d  = bad;
        cnt_d   = '0;
        acnt_d  = '0;
        rcnt_d  = '0;
        state_d = bad ? DONE : CFG;
      end
      CFG: begin
        cnt_d   = '0;
        state_d = ldw_q ? LOAD_W : STREAM;
      end
      LOAD_W: if (w_hs) begin
        if (cnt_q == W16 - 16'd1) begin cnt_d = '0; state_d = BURST; end
        else cnt_d = cnt_q + 16'd1;
      end
      BURST: begin
        if (cnt_q == W16 - 16'd1) begin cnt_d = '0; state_d = SWITCH; end
        else cnt_d = cnt_q + 16'd1;
      end
      SWITCH: begin cnt_d = '0; state_d = SETTLE; end
      SETTLE: begin
        if (cnt_q == 16'(2*WIDTH-1)) begin
          cnt_d   = '0;
          state_d = (rows_q == 16'd0) ? DRAIN : STREAM;
        end else cnt_d = cnt_q + 16'd1;
      end
      STREAM: begin
        acnt_d = acnt_q + 16'(a_hs);
        if (acnt_d == rows_q) state_d = (rcnt_d == rows_q) ? DONE : DRAIN;
      end
      DRAIN:   if (rcnt_d == rows_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bypass covers WIDTH=1, where the only row is written on the edge BURST begins
  always_comb begin
    wrow      = (w_hs && cnt_q == cnt_d) ? w_data : wbuf_q[bidx];
    colmask_d = '0;
    wrow_m    = '0;
    adat_m    = '0;
    for (int j = 0; j < WIDTH; j++) begin
      colmask_d[j] = 16'(j) < cols_d;
      if (colmask_d[j]) wrow_m[8*j +: 8] = wrow[8*j +: 8];
      if (colmask_q[j]) adat_m[8*j +: 8] = a_data[8*j +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {cnt_q, acnt_q, rcnt_q, cols_q, rows_q, ldw_q, errf_q} <= '0;
      wbuf_q <= '0;
      {cmd_ready_q, w_ready_q, a_ready_q, switch_q, csv_q, done_q, err_q} <= '0;
      {col_size_q, weight_q, accept_q, inj_d_q, inj_s_q, colmask_q} <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acnt_q    <= acnt_d;
      rcnt_q    <= rcnt_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      ldw_q     <= ldw_d;
      errf_q    <= errf_d;
      colmask_q <= colmask_d;
      if (w_hs) wbuf_q[widx] <= w_data;
      cmd_ready_q <= state_d == IDLE;
      csv_q       <= state_d == CFG;
      if (state_d == CFG) col_size_q <= cols_d;
      w_ready_q   <= state_d == LOAD_W;
      weight_q    <= (state_d == BURST) ? wrow_m : '0;
      accept_q    <= (state_d == BURST) ? colmask_d : '0;
      switch_q    <= state_d == SWITCH;
      a_ready_q   <= (state_d == STREAM) && (acnt_d < rows_d);
      done_q      <= state_d == DONE;
      err_q       <= (state_d == DONE) && errf_d;
      inj_d_q     <= a_hs ? adat_m : '0;
      inj_s_q     <= a_hs ? colmask_q : '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    systolic_skew_lane #(.DLY(i)) u_lane (
      .clk (clk),
      .rst (rst),
      .d_i (inj_d_q[8*i +: 8]),
      .s_i (inj_s_q[i]),
      .d_o (sys_data_out[8*i +: 8]),
      .s_o (sys_start_out[i])
    );
  end

  assign cmd_ready          = cmd_ready_q;
  assign w_ready            = w_ready_q;
  assign a_ready            = a_ready_q;
  assign sys_weight_out     = weight_q;
  assign sys_accept_w_out   = accept_q;
  assign sys_switch_out     = switch_q;
  assign col_size_out       = col_size_q;
  assign col_size_valid_out = csv_q;
  assign done               = done_q;
  assign err                = err_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] pcyc_q, pstall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcyc_q   <= '0;
      pstall_q <= '0;
    end else if (acc) begin
      pcyc_q   <= 32'd1;
      pstall_q <= '0;
    end else begin
      if (state_q != IDLE && pcyc_q != '1) pcyc_q <= pcyc_q + 32'd1;
      if (state_q == STREAM && a_ready_q && !a_valid && pstall_q != '1)
        pstall_q <= pstall_q + 32'd1;
    end
  end
  assign perf_cycles = pcyc_q;
  assign perf_stall  = pstall_q;
`else
  assign perf_cycles = '0;
  assign perf_stall  = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl at WIDTH=2: command table with weight/activation scoreboards,
// plus reset-during-settle sequence.
module tb_systolic_ctrl;
  localparam int W = 2;

  logic             clk = 1'b0, rst = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready, cmd_load_w = 1'b0;
  logic [15:0]      cmd_cols = '0, cmd_rows = '0;
  logic             w_valid = 1'b0, w_ready, a_valid = 1'b0, a_ready;
  logic [8*W-1:0]   w_data = '0, a_data = '0;
  logic [8*W-1:0]   sys_data_out, sys_weight_out;
  logic [W-1:0]     sys_start_out, sys_accept_w_out, sys_valid_in;
  logic             sys_switch_out, col_size_valid_out, done, err;
  logic [15:0]      col_size_out;
  logic [31:0]      perf_cycles, perf_stall;

  systolic_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cols(cmd_cols), .cmd_rows(cmd_rows), .cmd_load_w(cmd_load_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .sys_data_out(sys_data_out), .sys_start_out(sys_start_out),
    .sys_weight_out(sys_weight_out), .sys_accept_w_out(sys_accept_w_out),
    .sys_switch_out(sys_switch_out), .col_size_out(col_size_out),
    .col_size_valid_out(col_size_valid_out), .sys_valid_in(sys_valid_in),
    .done(done), .err(err), .perf_cycles(perf_cycles), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // array model: valid echoes start one cycle later, or a manual override
  logic [W-1:0] echo_q = '0, man_vld = '0;
  logic         man = 1'b0;
  always @(posedge clk) echo_q <= sys_start_out;
  assign sys_valid_in = man ? man_vld : echo_q;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] d; int due; } ent_t;
  ent_t           lq[W][$];
  logic [8*W-1:0] wq[$];
  int cur_cols = 0, gap_left = 0, wgap_left = 0, w_cnt = 0, a_cnt = 0;
  int n_acc = 0, n_sw = 0, n_csv = 0, n_start = 0, last_cols = 0;
  logic drv_fixed = 1'b0;

  function automatic logic [W-1:0] cmask(input int c);
    logic [W-1:0] m;
    for (int j = 0; j < W; j++) m[j] = (j < c);
    return m;
  endfunction

  // stream drivers react to ready one cycle at a time
  initial forever begin
    @(posedge clk); #1;
    w_data = drv_fixed ? ((w_cnt == 0) ? 16'h0A05 : 16'h0403) : (8*W)'($urandom);
    a_data = drv_fixed ? 16'h0002 : (8*W)'($urandom);
    if (w_ready && w_cnt == 1 && wgap_left > 0) begin w_valid = 1'b0; wgap_left--; end
    else w_valid = w_ready;
    if (a_ready && a_cnt == 1 && gap_left > 0) begin a_valid = 1'b0; gap_left--; end
    else a_valid = a_ready;
  end

  // monitor: fills scoreboards on handshakes, drains them on array-side outputs
  logic [8*W-1:0] mrow;
  logic           z_ok;
  ent_t           me;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (w_valid && w_ready) begin
        mrow = w_data;
        for (int j = 0; j < W; j++) if (j >= cur_cols) mrow[8*j +: 8] = 8'd0;
        wq.push_back(mrow);
        w_cnt++;
      end
      if (a_valid && a_ready) begin
        for (int i = 0; i < W; i++)
          if (i < cur_cols) lq[i].push_back('{a_data[8*i +: 8], cyc + 2 + i});
        a_cnt++;
      end
      if (sys_accept_w_out != '0) begin
        n_acc++;
        if (wq.size() == 0) chk("burst_unexpected", 1, 0);
        else begin
          mrow = wq.pop_front();
          chk("burst_weight", sys_weight_out, mrow);
          chk("burst_accept", sys_accept_w_out, cmask(cur_cols));
        end
      end
      if (sys_switch_out) n_sw++;
      if (col_size_valid_out) n_csv++;
      z_ok = 1'b1;
      for (int i = 0; i < W; i++) begin
        if (sys_start_out[i]) begin
          n_start++;
          if (lq[i].size() == 0) chk("start_unexpected", i, 99);
          else begin
            me = lq[i].pop_front();
            chk("act_data", sys_data_out[8*i +: 8], me.d);
            chk("act_cycle", cyc, me.due);
          end
        end else if (sys_data_out[8*i +: 8] != 8'd0) z_ok = 1'b0;
      end
      if (!z_ok) chk("data_without_start", 0, 1);
    end
  end

  typedef struct {
    logic [15:0] cols, rows;
    logic        ld;
    int          gap, wgap;
    logic        man, fixd, err;
    int          span;
  } vec_t;
  vec_t tbl[9];

  task automatic issue(input logic [15:0] c, input logic [15:0] r, input logic l, output int t);
    int k = 0;
    @(posedge clk); #1;
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_cols = c; cmd_rows = r; cmd_load_w = l;
    @(posedge clk); #1;
    t = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic prep(input vec_t v);
    wq.delete();
    for (int i = 0; i < W; i++) lq[i].delete();
    {w_cnt, a_cnt, n_acc, n_sw, n_csv, n_start} = '0;
    cur_cols  = v.err ? 0 : int'(v.cols);
    gap_left  = v.gap;
    wgap_left = v.wgap;
    drv_fixed = v.fixd;
    man       = v.man;
    man_vld   = v.man ? '1 : '0;
  endtask

  task automatic run_cmd(input vec_t v);
    int t, dc, pend;
    logic got = 1'b0;
    prep(v);
    issue(v.cols, v.rows, v.ld, t);
    dc = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (cyc == t) chk("cfg_valid_at_T1", col_size_valid_out, !v.err);
      if (done) begin got = 1'b1; dc = cyc; end
    end
    if (!got) chk("done_timeout", 0, 1);
    else begin
      chk("span", dc - t + 2, v.span);
      chk("err", err, v.err);
      chk("ready_in_done", cmd_ready, 0);
      @(negedge clk);
      chk("ready_after_done", cmd_ready, 1);
      chk("done_one_cycle", done, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, v.span);
      chk("perf_stall", perf_stall, v.gap);
`else
      chk("perf_cycles_off", perf_cycles, 0);
      chk("perf_stall_off", perf_stall, 0);
`endif
    end
    man_vld = '0;
    repeat (4) @(negedge clk);
    man = 1'b0;
    pend = wq.size();
    for (int i = 0; i < W; i++) pend += lq[i].size();
    chk("scoreboard_empty", pend, 0);
    chk("n_accept", n_acc, (!v.err && v.ld) ? W : 0);
    chk("n_switch", n_sw, (!v.err && v.ld) ? 1 : 0);
    chk("n_cfg", n_csv, v.err ? 0 : 1);
    chk("n_start", n_start, v.err ? 0 : int'(v.rows) * int'(v.cols));
    if (!v.err) last_cols = int'(v.cols);
    chk("col_size", col_size_out, last_cols);
  endtask

  vec_t post;
  int   tr;
  initial begin
    //         cols   rows   ld   gap wgap man  fixd err  span
    tbl[0] = '{16'd2, 16'd1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 17};
    tbl[1] = '{16'd1, 16'd3, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 10};
    tbl[2] = '{16'd0, 16'd1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2};
    tbl[3] = '{16'd3, 16'd1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2};
    tbl[4] = '{16'd2, 16'd0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 13};
    tbl[5] = '{16'd2, 16'd4, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 13};
    tbl[6] = '{16'd1, 16'd2, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 18};
    tbl[7] = '{16'hFFFF, 16'd5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2};
    tbl[8] = '{16'd1, 16'd2, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 5};
    post   = '{16'd2, 16'd1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 8};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {cmd_ready, w_ready, a_ready, sys_data_out, sys_start_out,
        sys_weight_out, sys_accept_w_out, sys_switch_out, col_size_out,
        col_size_valid_out, done, err, perf_cycles != 0, perf_stall != 0}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    for (int n = 0; n < 9; n++) run_cmd(tbl[n]);

    // reset in the middle of SETTLE must clear everything at once
    prep(tbl[0]);
    issue(16'd2, 16'd1, 1'b1, tr);
    repeat (9) @(negedge clk);
    chk("pre_reset_cycle", cyc, tr + 8);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {cmd_ready, w_ready, a_ready, sys_data_out, sys_start_out,
        sys_weight_out, sys_accept_w_out, sys_switch_out, col_size_out,
        col_size_valid_out, done, err, perf_cycles != 0, perf_stall != 0}, 0);
    repeat (2) @(negedge clk);
    chk("no_done_in_reset", done, 0);
    rst = 1'b1;
    last_cols = 0;
    run_cmd(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
